// File: rtl/imem_fetch_loader.sv
// ----------------------------------------------------------------------------
// imem_fetch_loader : instruction memory with 1-cycle fetch and streaming loader
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module imem_fetch_loader #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DEPTH     = 128,
  parameter bit                BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_INST  = '0,
  parameter string             INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic                       req_i,
  input  logic                       stall_i,
  output logic [DATA_W-1:0]          inst_o,
  output logic                       inst_valid_o,
  output logic                       misalign_err_o,
  output logic                       range_err_o,
  input  logic                       ld_start_i,
  input  logic                       ld_wr_i,
  input  logic                       ld_last_i,
  input  logic [DATA_W-1:0]          ld_data_i,
  output logic                       ld_busy_o,
  output logic                       ld_done_o,
  output logic [$clog2(DEPTH+1)-1:0] ld_count_o
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q, state_d;
  logic [CW-1:0]     wptr_q, wptr_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic [IW-1:0]     mem_waddr;

  logic [DATA_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              mis_q, mis_d;
  logic              rng_q, rng_d;

  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_misalign;
  logic              fetch_in_range;

  if (BYTE_ADDR) begin : g_byte_pc
    assign fetch_idx      = {2'b00, pc_i[ADDR_W-1:2]};
    assign fetch_misalign = |pc_i[1:0];
  end else begin : g_word_pc
    assign fetch_idx      = pc_i;
    assign fetch_misalign = 1'b0;
  end

  // Full-width compare so out-of-range PCs never alias onto a valid word.
  assign fetch_in_range = (fetch_idx < ADDR_W'(DEPTH));

  // Loader FSM: start always wins and may carry the first word with it.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wptr_q[IW-1:0];
    if (ld_start_i) begin
      state_d = S_LOAD;
      wptr_d  = '0;
      if (ld_wr_i) begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        wptr_d    = CW'(1);
      end
    end else if (state_q == S_LOAD && ld_wr_i) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + CW'(1);
      if (ld_last_i || wptr_q == CW'(DEPTH - 1)) begin
        state_d = S_RUN;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    inst_d  = inst_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    rng_d   = rng_q;
    if (!stall_i) begin
      if (state_q == S_RUN && req_i) begin
        valid_d = 1'b1;
        if (fetch_misalign) begin
          inst_d = NOP_INST;
          mis_d  = 1'b1;
          rng_d  = 1'b0;
        end else if (!fetch_in_range) begin
          inst_d = NOP_INST;
          mis_d  = 1'b0;
          rng_d  = 1'b1;
        end else begin
          inst_d = mem_q[fetch_idx[IW-1:0]];
          mis_d  = 1'b0;
          rng_d  = 1'b0;
        end
      end else begin
        valid_d = 1'b0;
        mis_d   = 1'b0;
        rng_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      wptr_q  <= '0;
      done_q  <= 1'b0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      done_q  <= done_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      rng_q   <= rng_d;
    end
  end

  // Storage is deliberately outside reset so a partial image survives rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= ld_data_i;
    end
  end

  assign inst_o         = inst_q;
  assign inst_valid_o   = valid_q;
  assign misalign_err_o = mis_q;
  assign range_err_o    = rng_q;
  assign ld_busy_o      = (state_q == S_LOAD);
  assign ld_done_o      = done_q;
  assign ld_count_o     = wptr_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_loader.sv
// Scoreboard bench for imem_fetch_loader: directed scenarios then random traffic
// against a queue/array reference model.
`default_nettype none

module tb_imem_fetch_loader;

  localparam int          DEPTH = 8;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP   = 32'hFFFF_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc = '0;
  logic          req = 1'b0, stall = 1'b0;
  logic          ld_start = 1'b0, ld_wr = 1'b0, ld_last = 1'b0;
  logic [31:0]   ld_data = '0;
  logic [31:0]   inst;
  logic          inst_valid, mis_err, rng_err, ld_busy, ld_done;
  logic [CW-1:0] ld_count;

  imem_fetch_loader #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BYTE_ADDR(1'b1),
    .NOP_INST(NOP), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .req_i(req), .stall_i(stall),
    .inst_o(inst), .inst_valid_o(inst_valid), .misalign_err_o(mis_err),
    .range_err_o(rng_err), .ld_start_i(ld_start), .ld_wr_i(ld_wr),
    .ld_last_i(ld_last), .ld_data_i(ld_data), .ld_busy_o(ld_busy),
    .ld_done_o(ld_done), .ld_count_o(ld_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] inst;
    bit          mis;
    bit          rng;
    bit          known;
  } fetch_t;

  fetch_t      sb_q[$];
  logic [31:0] m_mem [DEPTH];
  bit          m_kn  [DEPTH];
  bit          m_load;
  int          m_wptr;
  bit          e_done, e_valid, e_mis, e_rng, e_known;
  logic [31:0] e_inst;
  bit          fetch_edge;

  initial for (int i = 0; i < DEPTH; i++) m_kn[i] = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load = 0; m_wptr = 0; e_done = 0;
      e_valid = 0; e_mis = 0; e_rng = 0;
      e_inst = NOP; e_known = 1; fetch_edge = 0;
      sb_q.delete();
    end else begin
      fetch_t f;
      longint unsigned idx;
      fetch_edge = 0;
      if (!stall) begin
        if (m_load || !req) begin
          e_valid = 0; e_mis = 0; e_rng = 0;
        end else begin
          idx = longint'(pc) / 4;
          f.known = 1;
          f.mis = (pc % 4) != 0;
          f.rng = !f.mis && idx >= DEPTH;
          if (f.mis || f.rng) f.inst = NOP;
          else begin
            f.inst  = m_mem[idx];
            f.known = m_kn[idx];
          end
          e_valid = 1; e_mis = f.mis; e_rng = f.rng;
          e_inst = f.inst; e_known = f.known;
          sb_q.push_back(f);
          fetch_edge = 1;
        end
      end
      e_done = 0;
      if (ld_start) begin
        m_load = 1; m_wptr = 0;
        if (ld_wr) begin
          m_mem[0] = ld_data; m_kn[0] = 1; m_wptr = 1;
        end
      end else if (m_load && ld_wr) begin
        m_mem[m_wptr] = ld_data; m_kn[m_wptr] = 1;
        m_wptr++;
        if (ld_last || m_wptr == DEPTH) begin
          m_load = 0; e_done = 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ctrl{busy,done,cnt,valid,mis,rng}",
          64'({ld_busy, ld_done, ld_count, inst_valid, mis_err, rng_err}),
          64'({m_load, e_done, CW'(m_wptr), e_valid, e_mis, e_rng}));
      if (e_known) chk("inst_hold", 64'(inst), 64'(e_inst));
      if (fetch_edge) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL sb_empty: fetch edge with no expected entry at %0t", $time);
        end else begin
          fetch_t f;
          f = sb_q.pop_front();
          chk("fetch_valid", 64'(inst_valid), 64'(1));
          chk("fetch_errs", 64'({mis_err, rng_err}), 64'({f.mis, f.rng}));
          if (f.known) chk("fetch_inst", 64'(inst), 64'(f.inst));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rq, input bit st, input logic [31:0] p,
                       input bit s, input bit w, input bit l, input logic [31:0] d);
    req = rq; stall = st; pc = p;
    ld_start = s; ld_wr = w; ld_last = l; ld_data = d;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] p);
    drive(1, 0, p, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          r;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle();

    // Load A,B,C then fetch them back
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h1111_AAAA);
    drive(0, 0, 0, 0, 1, 0, 32'h2222_BBBB);
    drive(0, 0, 0, 0, 1, 1, 32'h3333_CCCC);
    idle();
    fetch(0); fetch(4); fetch(8); idle();

    // Stall holds B while pc moves on
    fetch(4);
    repeat (3) drive(1, 1, 32'd8, 0, 0, 0, 0);
    fetch(8); idle();

    // Error flags and priority
    fetch(2); fetch(DEPTH * 4); fetch(DEPTH * 4 - 2); fetch(32'hFFFF_FFFC);
    fetch(32'h0000_0003); fetch(0); idle();

    // Auto-end after DEPTH writes; extras ignored
    drive(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) drive(0, 0, 0, 0, 1, 0, 32'hA000_0000 + i);
    idle();
    for (int i = 0; i < DEPTH; i++) fetch(i * 4);
    // Start with concurrent write lands in word 0
    drive(0, 0, 0, 1, 1, 0, 32'h5555_0000);
    drive(0, 0, 0, 0, 1, 1, 32'h5555_0001);
    idle();
    fetch(0); fetch(4); fetch(8); idle();

    // Reset in the middle of a load keeps the partial image
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 32'h7777_0000);
    drive(0, 0, 0, 0, 1, 0, 32'h7777_0001);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst{inst,valid,busy,done,cnt}",
        64'({inst, inst_valid, ld_busy, ld_done, ld_count}),
        64'({NOP, 1'b0, 1'b0, 1'b0, CW'(0)}));
    @(negedge clk); #1 rst_n = 1'b1;
    idle();
    fetch(0); fetch(4); fetch(8); idle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = $urandom_range(0, DEPTH - 1) * 4;
      else if (r == 7) a = ($urandom_range(0, DEPTH - 1) * 4) + $urandom_range(1, 3);
      else if (r == 8) a = (DEPTH + $urandom_range(0, 20)) * 4;
      else             a = $urandom;
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, a,
            $urandom_range(0, 99) < 4, $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < 15, $urandom);
    end
    idle(); idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

`default_nettype wire
